serial_rx: RTL and testbench

//  Asynchronous serial receiver for the comms port: recovers 8N1 frames

---
 rtl/serial_pkg.sv | 30 +++
 rtl/serial_rx_sync.sv | 56 +++++
 rtl/serial_rx.sv | 273 +++++++++++++++++++++++++++
 tb/tb_serial_rx.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_pkg
// Description : Shared definitions for the comms-port serial receiver and
//               transmitter: receiver state encoding, bit timing constants
//               and the 3-sample majority helper.
// Revision    : 1.0  initial release
// ============================================================================
package serial_pkg;

  // Receiver states. RX_PARITY is only reachable when parity is compiled in.
  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_PARITY    = 3'd3,
    RX_STOP      = 3'd4,
    RX_WAIT_HIGH = 3'd5
  } rx_state_t;

  localparam int TICKS_PER_BIT = 16;
  localparam int VOTE_TICK0    = 7;   // samples at ticks 7,8,9 of a bit
  localparam int TICK_W        = $clog2(TICKS_PER_BIT);

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : serial_rx_sync
// Description : Two-flop synchroniser for RXD, falling-edge detector on the
//               synchronised line and a 3-sample majority voter.
// Ports       : i_clk        system clock
//               i_rst_n      asynchronous reset, active low
//               i_rxd        raw serial line (asynchronous, idle high)
//               i_sample_en  capture a vote sample this cycle (ticks 7, 8)
//               o_rxd_s      synchronised line
//               o_fall_edge  synchronised 1->0 transition
//               o_vote       majority of the two stored samples and the
//                            current synchronised value (valid at tick 9)
// Revision    : 1.0  initial release
// ============================================================================
module serial_rx_sync
  import serial_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_rxd,
  input  logic i_sample_en,
  output logic o_rxd_s,
  output logic o_fall_edge,
  output logic o_vote
);

  logic       r_meta;
  logic       r_rxd_s;
  logic       r_rxd_d;
  logic [1:0] r_samp;

  // All flops reset to the idle (high) line level so that release of reset
  // never looks like a start edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta  <= 1'b1;
      r_rxd_s <= 1'b1;
      r_rxd_d <= 1'b1;
      r_samp  <= 2'b11;
    end else begin
      r_meta  <= i_rxd;
      r_rxd_s <= r_meta;
      r_rxd_d <= r_rxd_s;
      if (i_sample_en) begin
        r_samp <= {r_samp[0], r_rxd_s};
      end
    end
  end

  assign o_rxd_s     = r_rxd_s;
  assign o_fall_edge = r_rxd_d & ~r_rxd_s;
  assign o_vote      = maj3(r_samp[1], r_samp[0], r_rxd_s);

endmodule
`default_nettype wire

// File: rtl/serial_rx.sv
`default_nettype none
// ============================================================================
// Module      : serial_rx
// Description : Asynchronous serial receiver (8N1, optional even parity).
//               Recovers frames from RXD and presents bytes on a
//               valid/ready interface with a single holding register.
//               Optional feature macro: SERIAL_RX_PARITY_EN (even parity
//               bit after the data bits; PAR_ERR tied low when undefined).
// Ports       : i_clk        system clock
//               i_rst_n      asynchronous reset, active low
//               i_rxd        serial line, asynchronous, idle high
//               o_data       received byte, stable while o_valid=1
//               o_valid      o_data holds an unconsumed byte
//               i_ready      consumer accepts o_data when o_valid&i_ready
//               o_frame_err  1-cycle pulse: stop bit sampled low
//               o_overrun    1-cycle pulse: byte completed, holding reg full
//               o_par_err    1-cycle pulse: parity mismatch
// Revision    : 1.0  initial release
// ============================================================================
module serial_rx
  import serial_pkg::*;
#(
  parameter int CLK_DIV = 13,
  parameter int DATA_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_rxd,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_frame_err,
  output logic              o_overrun,
  output logic              o_par_err
);

  localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  rx_state_t         r_state;
  rx_state_t         w_state_nxt;

  logic [PRE_W-1:0]  r_pre;
  logic [TICK_W-1:0] r_tick_cnt;
  logic [TICK_W-1:0] w_tick_num;
  logic              w_running;
  logic              w_tick;
  logic              w_sample_en;
  logic              w_vote_evt;

  logic              w_rxd_s;
  logic              w_fall;
  logic              w_vote;

  logic [BIT_W-1:0]  r_bit_idx;
  logic              w_last_bit;
  logic [DATA_W-1:0] r_shift;

  logic              w_deliver;
  logic              w_frame_err_evt;
  logic              w_par_bad;
  logic              w_deliver_ok;

  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_frame_err;
  logic              r_overrun;

  serial_rx_sync u_sync (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_rxd       (i_rxd),
    .i_sample_en (w_sample_en),
    .o_rxd_s     (w_rxd_s),
    .o_fall_edge (w_fall),
    .o_vote      (w_vote)
  );

  // --------------------------------------------------------------------------
  // Tick generation. r_tick_cnt holds the number of ticks already elapsed in
  // the current bit (mod 16); w_tick_num is the number of the tick firing now.
  // The cycle in which the start edge is seen already counts as prescaler
  // cycle 0, which keeps the stop-bit vote within 2+CLK_DIV cycles of the
  // stop-bit midpoint.
  // --------------------------------------------------------------------------
  assign w_running   = (r_state == RX_START) || (r_state == RX_DATA) ||
                       (r_state == RX_PARITY) || (r_state == RX_STOP);
  assign w_tick      = w_running && (r_pre == PRE_W'(CLK_DIV - 1));
  assign w_tick_num  = r_tick_cnt + 1'b1;
  assign w_sample_en = w_tick && ((w_tick_num == TICK_W'(VOTE_TICK0)) ||
                                  (w_tick_num == TICK_W'(VOTE_TICK0 + 1)));
  assign w_vote_evt  = w_tick && (w_tick_num == TICK_W'(VOTE_TICK0 + 2));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pre      <= '0;
      r_tick_cnt <= '0;
    end else if (r_state == RX_IDLE) begin
      r_pre      <= '0;
      r_tick_cnt <= '0;
      if (w_fall) begin
        if (CLK_DIV == 1) begin
          r_tick_cnt <= TICK_W'(1);
        end else begin
          r_pre <= PRE_W'(1);
        end
      end
    end else if (!w_running) begin
      r_pre      <= '0;
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_pre      <= '0;
      r_tick_cnt <= w_tick_num;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Receive FSM
  // --------------------------------------------------------------------------
  assign w_last_bit = (r_bit_idx == BIT_W'(DATA_W - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= RX_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_deliver       = 1'b0;
    w_frame_err_evt = 1'b0;
    case (r_state)
      RX_IDLE: begin
        if (w_fall) begin
          w_state_nxt = RX_START;
        end
      end
      RX_START: begin
        if (w_vote_evt) begin
          w_state_nxt = w_vote ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (w_vote_evt && w_last_bit) begin
`ifdef SERIAL_RX_PARITY_EN
          w_state_nxt = RX_PARITY;
`else
          w_state_nxt = RX_STOP;
`endif
        end
      end
      RX_PARITY: begin
        if (w_vote_evt) begin
          w_state_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        if (w_vote_evt) begin
          if (w_vote) begin
            w_deliver   = 1'b1;
            w_state_nxt = RX_IDLE;
          end else begin
            w_frame_err_evt = 1'b1;
            w_state_nxt     = RX_WAIT_HIGH;
          end
        end
      end
      RX_WAIT_HIGH: begin
        // A break keeps the line low; stay here until it returns high.
        if (w_rxd_s) begin
          w_state_nxt = RX_IDLE;
        end
      end
      default: begin
        w_state_nxt = RX_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Bit counter, shift register (LSB first) and parity capture
  // --------------------------------------------------------------------------
`ifdef SERIAL_RX_PARITY_EN
  logic r_par_bit;
  logic r_par_err;

  // Even parity: data bits plus parity bit must contain an even number of 1s.
  assign w_par_bad = ^{r_shift, r_par_bit};
`else
  assign w_par_bad = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bit_idx <= '0;
      r_shift   <= '0;
`ifdef SERIAL_RX_PARITY_EN
      r_par_bit <= 1'b0;
`endif
    end else if (w_vote_evt) begin
      case (r_state)
        RX_START: begin
          r_bit_idx <= '0;
        end
        RX_DATA: begin
          r_shift   <= {w_vote, r_shift[DATA_W-1:1]};
          r_bit_idx <= r_bit_idx + 1'b1;
        end
`ifdef SERIAL_RX_PARITY_EN
        RX_PARITY: begin
          r_par_bit <= w_vote;
        end
`endif
        default: begin
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Holding register and error pulses. A frame produces at most one of
  // delivery, FRAME_ERR, PAR_ERR or OVERRUN.
  // --------------------------------------------------------------------------
  assign w_deliver_ok = w_deliver && !w_par_bad;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_frame_err_evt;
      r_overrun   <= 1'b0;
      if (w_deliver_ok) begin
        // Load when empty, or when the held byte is consumed this same cycle.
        if (!r_valid || i_ready) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef SERIAL_RX_PARITY_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_par_err <= 1'b0;
    end else begin
      r_par_err <= w_deliver && w_par_bad;
    end
  end

  assign o_par_err = r_par_err;
`else
  assign o_par_err = 1'b0;
`endif

  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_frame_err = r_frame_err;
  assign o_overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_serial_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_rx
// Description : Self-checking bench for serial_rx (CLK_DIV=2, 32 clocks per
//               bit). A frame-level model predicts delivery, holding-register
//               contents and error pulses; a per-cycle monitor checks the
//               interface rules. Parity cases run when SERIAL_RX_PARITY_EN
//               is defined.
// Revision    : 1.0  initial release
// ============================================================================
module tb_serial_rx;

  localparam int CLK_DIV = 2;
  localparam int DATA_W  = 8;
  localparam int BIT     = 16 * CLK_DIV;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rxd = 1'b1;
  logic              ready = 1'b0;
  logic [DATA_W-1:0] o_data;
  logic              o_valid;
  logic              o_frame_err;
  logic              o_overrun;
  logic              o_par_err;

  serial_rx #(.CLK_DIV(CLK_DIV), .DATA_W(DATA_W)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_rxd       (rxd),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (ready),
    .o_frame_err (o_frame_err),
    .o_overrun   (o_overrun),
    .o_par_err   (o_par_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

`ifdef SERIAL_RX_PARITY_EN
  logic g_par_flip = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Per-cycle monitor
  // --------------------------------------------------------------------------
  int   n_rise = 0, n_ferr = 0, n_ovr = 0, n_perr = 0, rise_cyc = 0;
  logic p_valid = 1'b0, p_ready = 1'b0, p_ferr = 1'b0, p_ovr = 1'b0, p_perr = 1'b0;
  logic [DATA_W-1:0] p_data = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      p_valid = 1'b0; p_ferr = 1'b0; p_ovr = 1'b0; p_perr = 1'b0;
      p_ready = ready; p_data = o_data;
    end else begin
      if (p_valid && !p_ready)
        check("hold_stable", {o_valid, o_data}, {1'b1, p_data});
      if (o_valid && !p_valid) begin
        n_rise++;
        rise_cyc = cyc;
        check("no_err_on_valid", {o_frame_err, o_par_err}, 2'b00);
      end
      if (o_frame_err) begin n_ferr++; check("ferr_1cyc", p_ferr, 1'b0); end
      if (o_overrun)   begin n_ovr++;  check("ovr_1cyc",  p_ovr,  1'b0); end
      if (o_par_err)   begin n_perr++; check("perr_1cyc", p_perr, 1'b0); end
      if (o_frame_err || o_overrun || o_par_err)
        check("one_err", 32'(o_frame_err) + 32'(o_overrun) + 32'(o_par_err), 1);
`ifndef SERIAL_RX_PARITY_EN
      check("par_err_tied", o_par_err, 1'b0);
`endif
      p_valid = o_valid; p_ready = ready; p_data = o_data;
      p_ferr = o_frame_err; p_ovr = o_overrun; p_perr = o_par_err;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers (all start and end #1 after a rising edge)
  // --------------------------------------------------------------------------
  task automatic hold_line(input logic lvl, input int nbits);
    rxd = lvl;
    repeat (nbits * BIT) @(posedge clk);
    #1;
  endtask

  // One bit period; optional one-clock inversion just before the midpoint.
  task automatic send_bit(input logic b, input bit glitch);
    rxd = b;
    for (int j = 0; j < BIT; j++) begin
      if (glitch && j == BIT/2 - 1) rxd = ~b;
      if (glitch && j == BIT/2)     rxd = b;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input int glitch,
                            output int mid);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < DATA_W; i++) send_bit(d[i], glitch == i);
`ifdef SERIAL_RX_PARITY_EN
    send_bit((^d) ^ g_par_flip, 1'b0);
`endif
    mid = cyc + BIT/2;
    send_bit(stop_b, 1'b0);
  endtask

  // --------------------------------------------------------------------------
  // Frame-level model: holding register state and expected outcome
  // --------------------------------------------------------------------------
  logic              m_valid = 1'b0;
  logic [DATA_W-1:0] m_data  = '0;

  // 0 = good byte, 1 = framing error, 2 = parity error
  function automatic int outcome(input logic stop_b);
    if (!stop_b) return 1;
`ifdef SERIAL_RX_PARITY_EN
    if (g_par_flip) return 2;
`endif
    return 0;
  endfunction

  task automatic run_frame(input string tag, input logic [7:0] d, input logic stop_b,
                           input int glitch, input logic rdy);
    int r0, f0, o0, p0, mid, lat;
    int e_rise, e_f, e_o, e_p;
    r0 = n_rise; f0 = n_ferr; o0 = n_ovr; p0 = n_perr;
    e_rise = 0; e_f = 0; e_o = 0; e_p = 0;
    ready = rdy;
    if (rdy) m_valid = 1'b0;          // a held byte is taken straight away
    send_frame(d, stop_b, glitch, mid);
    case (outcome(stop_b))
      0: if (!m_valid) begin e_rise = 1; m_data = d; m_valid = !rdy; end
         else e_o = 1;
      1: e_f = 1;
      default: e_p = 1;
    endcase
    check({tag, "_rise"},  n_rise - r0, e_rise);
    check({tag, "_ferr"},  n_ferr - f0, e_f);
    check({tag, "_ovr"},   n_ovr  - o0, e_o);
    check({tag, "_perr"},  n_perr - p0, e_p);
    check({tag, "_valid"}, o_valid, m_valid);
    check({tag, "_data"},  o_data,  m_data);
    if (e_rise == 1) begin
      lat = rise_cyc - mid;
      check({tag, "_latency_ok"}, (lat >= 0) && (lat <= 2 + CLK_DIV), 1'b1);
    end
  endtask

  // --------------------------------------------------------------------------
  // Directed tests
  // --------------------------------------------------------------------------
  initial begin
    int r0, f0, o0, p0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {o_data, o_valid, o_frame_err, o_overrun, o_par_err}, '0);
    rst_n = 1'b1;
    hold_line(1'b1, 2);

    // 1: single frame consumed immediately
    run_frame("t1_5A", 8'h5A, 1'b1, -1, 1'b1);
    check("t1_data_lit", o_data, 8'h5A);

    // 2: back-to-back frames into a full holding register
    run_frame("t2_12", 8'h12, 1'b1, -1, 1'b0);
    run_frame("t2_F0", 8'hF0, 1'b1, -1, 1'b0);
    check("t2_held_lit", o_data, 8'h12);
    ready = 1'b1;
    check("t2_valid_before_accept", o_valid, 1'b1);
    @(posedge clk);
    #1;
    check("t2_valid_cleared", o_valid, 1'b0);
    check("t2_data_retained", o_data, 8'h12);
    m_valid = 1'b0;

    // 3: stop bit low, line held low (break), then recovery
    run_frame("t3_33", 8'h33, 1'b0, -1, 1'b1);
    hold_line(1'b0, 2);
    check("t3_break_no_valid", o_valid, 1'b0);
    hold_line(1'b1, 2);
    run_frame("t3_44", 8'h44, 1'b1, -1, 1'b0);
    check("t3_data_lit", o_data, 8'h44);

    // 4: short low glitch on idle line, then a glitched data bit
    ready = 1'b1;
    r0 = n_rise; f0 = n_ferr; o0 = n_ovr; p0 = n_perr;
    rxd = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    hold_line(1'b1, 2);
    m_valid = 1'b0;
    check("t4_false_start_events", {n_rise - r0, n_ferr - f0, n_ovr - o0, n_perr - p0}, '0);
    check("t4_false_start_valid", o_valid, 1'b0);
    run_frame("t4_A5", 8'hA5, 1'b1, 0, 1'b0);
    check("t4_data_lit", o_data, 8'hA5);

    // 5: reset in the middle of data bit 4 of 0x77
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1 & (8'h77 >> i), 1'b0);
    rxd = 1'b1;                        // bit 4 of 0x77 is 1
    repeat (BIT/2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_reset", {o_data, o_valid, o_frame_err, o_overrun, o_par_err}, '0);
    m_valid = 1'b0;
    m_data  = '0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold_line(1'b1, 2);
    check("t5_no_partial_byte", o_valid, 1'b0);
    run_frame("t5_81", 8'h81, 1'b1, -1, 1'b0);
    check("t5_data_lit", o_data, 8'h81);

`ifdef SERIAL_RX_PARITY_EN
    // 6: even parity good and bad
    g_par_flip = 1'b0;
    run_frame("t6_07_ok", 8'h07, 1'b1, -1, 1'b0);
    check("t6_data_lit", o_data, 8'h07);
    g_par_flip = 1'b1;
    run_frame("t6_07_bad", 8'h07, 1'b1, -1, 1'b1);
    check("t6_bad_valid", o_valid, 1'b0);
    g_par_flip = 1'b0;
`endif

    hold_line(1'b1, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
